smpc_pad_reader: RTL
====================

Name: smpc_pad_reader

Overview:
- SMPC-side initiator for one Saturn controller port.
- Runs the TH/TR/TL 3-wire handshake read: header nibble, ID byte, then the payload. It stores the payload in a byte buffer for the SMPC command engine to read out.
- Sits between the SMPC INTBACK peripheral collector and the port PDR/DDR pins. It is the host end of the protocol the pad emulators answer.

Parameters:
- MAX_BYTES, 8, payload buffer depth in bytes; a larger reported length is an error.
- SETTLE_TICKS, 2, CE ticks held after each TH/TR change before TL is sampled.
- TIMEOUT_TICKS, 255, CE ticks allowed per handshake step for TL to match TR.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  SMPC clock enable; all protocol timing advances only on CE
- START  in  1  one-CLK pulse, request a port read
- PDR_I  in  7  port pins as seen by the SMPC; [4]=TL, [3:0]=data nibble
- PDR_O  out  7  port output; [6]=TH, [5]=TR, [4:0]=0
- DDR  out  7  direction; constant 7'h60 (TH/TR outputs)
- BUSY  out  1  read in progress
- DONE  out  1  one-CLK pulse at end of read (success or error)
- ERR  out  1  error flag for the last read; held until next START
- ID  out  8  peripheral ID of the last read
- LEN  out  4  payload byte count of the last read
- RD_ADDR  in  3  buffer read address (log2 MAX_BYTES)
- RD_DATA  out  8  buffer byte, registered, 1-CLK latency

Behaviour:
- Reset values:
  - TH=TR=1; PDR_O=7'h60; DDR=7'h60.
  - BUSY=0, DONE=0, ERR=0, ID=0, LEN=0, RD_DATA=0.
  - FSM in IDLE; step and tick counters 0.
- START:
  - Latched as pending on any CLK in IDLE; acted on at the next CE.
  - START while BUSY is ignored.
  - Acting on START clears ERR and sets BUSY.
- States: IDLE -> DRIVE -> SETTLE -> WAIT_TL -> CAPTURE -> (DRIVE | FINISH), with FAIL on error.
- Step k (k=0..): DRIVE sets TH=0 and TR=~k[0]. Step 0 drives 01, step 1 drives 00, and so on.
- SETTLE counts SETTLE_TICKS CE ticks.
- WAIT_TL, on each CE:
  - If PDR_I[4]==TR, go to CAPTURE.
  - Otherwise increment the timeout counter; on reaching TIMEOUT_TICKS go to FAIL.
  - The timeout counter restarts at every DRIVE.
- CAPTURE: nibble = PDR_I[3:0].
  - Step 0 is the header H.
    - H==4'h1: 3-wire standard; read the ID in steps 1–2.
    - H==4'hB: short form; ID=8'hE3, LEN=3; steps 1–2 are read and discarded.
    - Any other H goes to FAIL.
  - Steps 1–2 (H==1): ID={n1,n2}, LEN=n2. LEN>MAX_BYTES goes to FAIL. LEN==0 goes straight to FINISH after step 2.
  - Payload steps 3..(2+2·LEN): even payload index gives the high nibble, odd gives the low nibble. The byte is written to buffer[(k-3)>>1] when its low nibble is captured.
- FINISH:
  - TH=TR=1 (pins back to 11).
  - BUSY=0 and DONE=1 for one CLK.
  - ID and LEN are valid.
- FAIL:
  - TH=TR=1; ERR=1; ID=8'hFF; LEN=0.
  - BUSY=0 and DONE=1 for one CLK.
- Buffer:
  - Contents are undefined after an error and stale bytes beyond LEN are kept.
  - RD_DATA=buffer[RD_ADDR] registered every CLK, reads allowed while BUSY.
- Total steps for a successful 3-wire read = 3+2·LEN.
- A step in progress holds TH/TR stable; TH/TR change only in DRIVE/FINISH/FAIL.
- CE low freezes all counters and the FSM; START latching still works.
- Reset mid-read aborts immediately to reset values without a DONE pulse.

Optional Feature:
- Macro: SMPC_PAD_DIGITAL_FALLBACK_EN.
- Defined: an invalid header H (not 1/B) does not fail. Instead the reader runs a direct-select digital read:
  - Drive TH/TR = 00, 01, 10, 11, each held SETTLE_TICKS+1 CE ticks, no TL check.
  - Sample the nibble at the end of each hold: q0..q3.
  - buffer[0]={q1,q2}, buffer[1]={q0,q3}.
  - ID=8'h02, LEN=2, ERR=0, then FINISH.
- Undefined: an invalid header goes to FAIL as above.

Test Plan:
- 3D pad responder (H=1, ID nibbles 1,6, payload 12 nibbles 0..B), START -> 15 handshakes, TR sequence 1,0,1,…; ID=8'h16, LEN=6, buffer = 01,23,45,67,89,AB; ERR=0; one DONE pulse; pins end at 11.
- Mouse-style responder (nibbles B,F,F, then 3,C,5,A,F,0) -> ID=8'hE3, LEN=3, buffer = 3C,5A,F0.
- Responder freezes TL=0 at step 2 (TR=1) -> after TIMEOUT_TICKS CE ticks: ERR=1, ID=FF, LEN=0, DONE pulse, pins 11.
- H=1 with ID 8'h19 (LEN 9 > 8) -> FAIL after step 2. Header 4'h7 -> FAIL without macro. With macro and digital pad nibbles q0..q3 = 4,F,E,C -> buffer[0]=8'hFE, buffer[1]=8'h4C, ID=8'h02.
- START pulsed again while BUSY -> ignored, single DONE. CE held low 50 CLK mid-read -> no state change.
- RST_N asserted at step 5 -> immediate reset values, no DONE. A new START afterwards completes normally.

Source files
------------

// File: rtl/smpc_pad_reader.sv
// SMPC-side TH/TR/TL handshake reader for one Saturn controller port.
// Optional SMPC_PAD_DIGITAL_FALLBACK_EN: an unknown header runs a direct-select digital read instead of failing.
module smpc_pad_reader #(
  parameter int MAX_BYTES     = 8,
  parameter int SETTLE_TICKS  = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         CE,
  input  logic                         START,
  input  logic [6:0]                   PDR_I,
  output logic [6:0]                   PDR_O,
  output logic [6:0]                   DDR,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR,
  output logic [7:0]                   ID,
  output logic [3:0]                   LEN,
  input  logic [$clog2(MAX_BYTES)-1:0] RD_ADDR,
  output logic [7:0]                   RD_DATA
);

  localparam int AW = $clog2(MAX_BYTES);
  localparam int SW = $clog2(2 * MAX_BYTES + 4);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int KW = $clog2(SETTLE_TICKS + 2);
  localparam logic [4:0] MAXB = 5'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_WAIT_TL, S_CAPTURE, S_FINISH, S_FAIL, S_DIG
  } state_t;

  state_t          r_state;
  logic            r_pend, r_th, r_tr, r_short;
  logic [SW-1:0]   r_step;
  logic [KW-1:0]   r_tick;
  logic [TW-1:0]   r_to;
  logic [3:0]      r_hi, r_lenw;
  logic [7:0]      r_idw;
  logic [7:0]      r_buf [MAX_BYTES];
`ifdef SMPC_PAD_DIGITAL_FALLBACK_EN
  logic [1:0]      r_dstep;
  logic [3:0]      r_q0, r_q1;
`endif

  logic [3:0]      w_nib;
  logic            w_tl;
  logic [AW:0]     w_pidx;
  logic [SW-1:0]   w_last;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic [7:0]      w_wr_data;
  logic            w_unused;

  assign w_nib    = PDR_I[3:0];
  assign w_tl     = PDR_I[4];
  assign w_unused = &{1'b0, PDR_I[6:5]};
  assign w_pidx   = (AW + 1)'(r_step - SW'(3));
  assign w_last   = SW'({r_lenw, 1'b0}) + SW'(2);
  assign PDR_O    = {r_th, r_tr, 5'b0};
  assign DDR      = 7'h60;

  // A payload byte is committed when its low (odd-index) nibble arrives.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    if (CE && r_state == S_CAPTURE && r_step >= SW'(3) && w_pidx[0]) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_pidx[AW:1];
      w_wr_data = {r_hi, w_nib};
    end
`ifdef SMPC_PAD_DIGITAL_FALLBACK_EN
    if (CE && r_state == S_DIG && r_tick == KW'(SETTLE_TICKS) && r_dstep[1]) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_dstep[0] ? AW'(1) : AW'(0);
      w_wr_data = r_dstep[0] ? {r_q0, w_nib} : {r_q1, w_nib};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_buf[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) RD_DATA <= '0;
    else        RD_DATA <= r_buf[RD_ADDR];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_th    <= 1'b1;
      r_tr    <= 1'b1;
      r_short <= 1'b0;
      r_step  <= '0;
      r_tick  <= '0;
      r_to    <= '0;
      r_hi    <= '0;
      r_lenw  <= '0;
      r_idw   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      ID      <= '0;
      LEN     <= '0;
`ifdef SMPC_PAD_DIGITAL_FALLBACK_EN
      r_dstep <= '0;
      r_q0    <= '0;
      r_q1    <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      if (r_state == S_IDLE && START) r_pend <= 1'b1;
      if (CE) begin
        case (r_state)
          S_IDLE: if (r_pend || START) begin
            r_pend  <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b1;
            r_step  <= '0;
            r_state <= S_DRIVE;
          end
          S_DRIVE: begin
            r_th    <= 1'b0;
            r_tr    <= ~r_step[0];
            r_tick  <= '0;
            r_to    <= '0;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_tick == KW'(SETTLE_TICKS - 1)) r_state <= S_WAIT_TL;
            else r_tick <= r_tick + 1'b1;
          end
          S_WAIT_TL: begin
            if (w_tl == r_tr) r_state <= S_CAPTURE;
            else if (r_to == TW'(TIMEOUT_TICKS - 1)) r_state <= S_FAIL;
            else r_to <= r_to + 1'b1;
          end
          S_CAPTURE: begin
            r_step  <= r_step + 1'b1;
            r_state <= S_DRIVE;
            if (r_step == '0) begin
              if (w_nib == 4'h1) r_short <= 1'b0;
              else if (w_nib == 4'hB) r_short <= 1'b1;
              else begin
`ifdef SMPC_PAD_DIGITAL_FALLBACK_EN
                r_th    <= 1'b0;
                r_tr    <= 1'b0;
                r_dstep <= '0;
                r_tick  <= '0;
                r_state <= S_DIG;
`else
                r_state <= S_FAIL;
`endif
              end
            end else if (r_step == SW'(1)) begin
              r_hi <= w_nib;
            end else if (r_step == SW'(2)) begin
              if (r_short) begin
                r_idw  <= 8'hE3;
                r_lenw <= 4'd3;
              end else begin
                r_idw  <= {r_hi, w_nib};
                r_lenw <= w_nib;
                if ({1'b0, w_nib} > MAXB) r_state <= S_FAIL;
                else if (w_nib == 4'd0) r_state <= S_FINISH;
              end
            end else begin
              if (!w_pidx[0]) r_hi <= w_nib;
              if (r_step == w_last) r_state <= S_FINISH;
            end
          end
`ifdef SMPC_PAD_DIGITAL_FALLBACK_EN
          // Each select pattern is held SETTLE_TICKS+1 ticks and sampled on the last one.
          S_DIG: begin
            if (r_tick == KW'(SETTLE_TICKS)) begin
              r_tick <= '0;
              if (r_dstep == 2'd0) r_q0 <= w_nib;
              if (r_dstep == 2'd1) r_q1 <= w_nib;
              if (r_dstep == 2'd3) begin
                r_idw   <= 8'h02;
                r_lenw  <= 4'd2;
                r_state <= S_FINISH;
              end else begin
                r_dstep      <= r_dstep + 2'd1;
                {r_th, r_tr} <= r_dstep + 2'd1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
`endif
          S_FINISH: begin
            r_th    <= 1'b1;
            r_tr    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            ID      <= r_idw;
            LEN     <= r_lenw;
            r_state <= S_IDLE;
          end
          S_FAIL: begin
            r_th    <= 1'b1;
            r_tr    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            ERR     <= 1'b1;
            ID      <= 8'hFF;
            LEN     <= 4'd0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
